// File: rtl/cla_seq_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit carry-lookahead slice reused per nibble, LSB first.
// Optional macro CLA_SEQ_OVF_EN adds a registered signed-overflow output (ovf).
module cla_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   ps_q, ps_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef CLA_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Nibble slice: fully expanded lookahead carries from generate/propagate
    logic [NIB_W-1:0] na_c, nb_c, g_c, p_c, sum_c;
    logic             c0_c, c1_c, c2_c, c3_c, c4_c;
    logic [WIDTH-1:0] ps_shift_c;

    always_comb begin
        na_c = a_q[NIB_W-1:0];
        nb_c = b_q[NIB_W-1:0];
        g_c  = na_c & nb_c;
        p_c  = na_c ^ nb_c;
        c0_c = carry_q;
        c1_c = g_c[0] | (p_c[0] & c0_c);
        c2_c = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & c0_c);
        c3_c = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
             | (p_c[2] & p_c[1] & p_c[0] & c0_c);
        c4_c = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
             | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
             | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & c0_c);
        sum_c = p_c ^ {c3_c, c2_c, c1_c, c0_c};
        // new sum nibble enters at the top; oldest nibble falls off the bottom
        ps_shift_c = WIDTH'({sum_c, ps_q} >> NIB_W);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        ps_d    = ps_q;
        s_d     = s_q;
        co_d    = co_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    ps_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                ps_d    = ps_shift_c;
                carry_d = c4_c;
                cnt_d   = cnt_q + CNT_W'(1);
                busy_d  = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    s_d     = ps_shift_c;
                    co_d    = c4_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = c3_c ^ c4_c;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            ps_q    <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            ps_q    <= ps_d;
            s_q     <= s_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed self-checking bench for cla_seq_ctrl at WIDTH=32.
module tb_cla_seq_ctrl;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ci_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    int n_assert;
    int n_fail;
    logic [WIDTH-1:0] prev_s;
    logic             prev_co;

    cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .ci    (ci_in),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full add with fixed-latency checks; operands are scrambled after acceptance
    task automatic do_add(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic civ, input logic [WIDTH-1:0] exp_s, input logic exp_co,
                          input logic exp_ovf);
        a_in  = av;
        b_in  = bv;
        ci_in = civ;
        start = 1'b1;
        step();
        start = 1'b0;
        a_in  = ~av;
        b_in  = ~bv;
        ci_in = ~civ;
        chk({tag, " busy/done after accept"}, 64'({busy, done}), 64'(2'b10));
        for (int i = 1; i < 8; i++) begin
            step();
            chk({tag, " busy/done in run"}, 64'({busy, done}), 64'(2'b10));
            chk({tag, " s/co hold in run"}, 64'({co, s}), 64'({prev_co, prev_s}));
        end
        step();
        chk({tag, " busy/done at completion"}, 64'({busy, done}), 64'(2'b01));
        chk({tag, " sum"}, 64'(s), 64'(exp_s));
        chk({tag, " carry out"}, 64'(co), 64'(exp_co));
`ifdef CLA_SEQ_OVF_EN
        chk({tag, " overflow"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf !== 1'b0 && exp_ovf !== 1'b1) $display("note: %s unknown ovf expectation", tag);
`endif
        prev_s  = exp_s;
        prev_co = exp_co;
        step();
        chk({tag, " idle after done"}, 64'({busy, done}), 64'(2'b00));
        chk({tag, " result holds"}, 64'({co, s}), 64'({exp_co, exp_s}));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        prev_s   = '0;
        prev_co  = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        ci_in    = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Idle after reset with start low
        for (int i = 0; i < 10; i++) begin
            chk("reset idle busy/done", 64'({busy, done}), 64'(2'b00));
            chk("reset idle s/co", 64'({co, s}), 64'(33'h0));
`ifdef CLA_SEQ_OVF_EN
            chk("reset idle ovf", 64'(ovf), 64'(1'b0));
`endif
            step();
        end

        do_add("1+1", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        do_add("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_add("pos ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_add("neg ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        do_add("mixed ci", 32'hDEAD_BEEF, 32'h1020_3040, 1'b1, 32'hEECD_EF30, 1'b0, 1'b0);

        // Start held high through RUN, operands zeroed mid-flight, then back-to-back
        a_in  = 32'h1234_5678;
        b_in  = 32'h1111_1111;
        ci_in = 1'b1;
        start = 1'b1;
        step();
        a_in  = '0;
        b_in  = '0;
        ci_in = 1'b0;
        chk("b2b first accept", 64'({busy, done}), 64'(2'b10));
        for (int i = 1; i < 8; i++) begin
            step();
            chk("b2b first run busy/done", 64'({busy, done}), 64'(2'b10));
        end
        step();
        chk("b2b first done", 64'({busy, done}), 64'(2'b01));
        chk("b2b first sum", 64'({co, s}), 64'({1'b0, 32'h2345_678A}));
        a_in  = 32'h0000_0005;
        b_in  = 32'h0000_0003;
        step();
        start = 1'b0;
        chk("b2b second accept", 64'({busy, done}), 64'(2'b10));
        chk("b2b s holds", 64'(s), 64'(32'h2345_678A));
        for (int i = 1; i < 8; i++) begin
            step();
            chk("b2b second run busy/done", 64'({busy, done}), 64'(2'b10));
        end
        step();
        chk("b2b second done", 64'({busy, done}), 64'(2'b01));
        chk("b2b second sum", 64'({co, s}), 64'({1'b0, 32'h0000_0008}));
        step();
        chk("b2b back to idle", 64'({busy, done}), 64'(2'b00));

        // Reset during the 4th RUN cycle aborts the add
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'hFFFF_FFFF;
        ci_in = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("abort busy before reset", 64'({busy, done}), 64'(2'b10));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy/done", 64'({busy, done}), 64'(2'b00));
        chk("abort s/co cleared", 64'({co, s}), 64'(33'h0));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort no done pulse", 64'({busy, done}), 64'(2'b00));
        end
        prev_s  = '0;
        prev_co = 1'b0;
        do_add("after abort", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
